// File: rtl/move_cmd.sv
// Turns debounced direction-button events into one move command per press,
// with auto-repeat while held, a one-entry output buffer and a drop counter.
module move_cmd #(
    parameter int DELAY  = 25_000_000,
    parameter int PERIOD = 10_000_000,
    parameter int CW     = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_level,
    input  logic [3:0] btn_tick,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       move_rep,
    output logic [7:0] drop_cnt,
    output logic [1:0] fsm_state
);

    // Handshake: a command transfers on a cycle where move_valid && move_ready;
    // move_dir/move_rep stay stable while move_valid is high and not accepted.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CW-1:0] DELAY_LOAD  = CW'(DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(PERIOD - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    held;
    logic          first;

    logic       any_tick;
    logic [1:0] winner;
    logic       released;
    logic       req;
    logic [1:0] req_dir;
    logic       req_rep;
    logic       accept;

    assign fsm_state = state;
    assign any_tick  = |btn_tick;
    assign accept    = move_valid && move_ready;

    always_comb begin
        winner = 2'd3;
        if (btn_tick[0])      winner = 2'd0;
        else if (btn_tick[1]) winner = 2'd1;
        else if (btn_tick[2]) winner = 2'd2;
    end

    // The grace cycle right after entering HOLD hides the tick-before-level skew.
    assign released = !btn_level[held] && !(state == HOLD && first);

    always_comb begin
        req     = 1'b0;
        req_dir = winner;
        req_rep = 1'b0;
        if (any_tick) begin
            req = 1'b1;
        end else if (state != IDLE && !released && cnt == '0) begin
            req     = 1'b1;
            req_dir = held;
            req_rep = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            held       <= 2'd0;
            first      <= 1'b0;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            move_rep   <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            first <= 1'b0;
            if (any_tick) begin
                held  <= winner;
                cnt   <= DELAY_LOAD;
                state <= HOLD;
                first <= 1'b1;
            end else if (state != IDLE) begin
                if (released) begin
                    state <= IDLE;
                end else if (cnt == '0) begin
                    cnt   <= PERIOD_LOAD;
                    state <= REPEAT;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end

            // The countdown above runs independently of back-pressure.
            if (req) begin
                if (!move_valid || move_ready) begin
                    move_valid <= 1'b1;
                    move_dir   <= req_dir;
                    move_rep   <= req_rep;
                end else if (drop_cnt != 8'hff) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (accept) begin
                move_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_move_cmd.sv
// Directed bench for move_cmd with DELAY=8, PERIOD=4; one task per scenario.
module tb_move_cmd;

    logic       clk;
    logic       reset;
    logic [3:0] btn_level;
    logic [3:0] btn_tick;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_rep;
    logic [7:0] drop_cnt;
    logic [1:0] fsm_state;

    int tests_run;
    int tests_failed;

    move_cmd #(.DELAY(8), .PERIOD(4), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_level (btn_level),
        .btn_tick  (btn_tick),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .move_rep  (move_rep),
        .drop_cnt  (drop_cnt),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset      = 1'b0;
        btn_level  = 4'd0;
        btn_tick   = 4'd0;
        move_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            btn_level  = 4'($urandom_range(0, 15));
            btn_tick   = 4'($urandom_range(0, 15));
            move_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (move_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%0b exp=0", move_valid); end
        tests_run++;
        if (move_dir !== 2'd0) begin tests_failed++; $display("FAIL reset_dir got=%0d exp=0", move_dir); end
        tests_run++;
        if (move_rep !== 1'b0) begin tests_failed++; $display("FAIL reset_rep got=%0b exp=0", move_rep); end
        tests_run++;
        if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        tests_run++;
        if (fsm_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
        reset      = 1'b1;
        btn_level  = 4'd0;
        btn_tick   = 4'd0;
        move_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (move_valid !== 1'b0 || fsm_state !== 2'd0) begin
                tests_failed++;
                $display("FAIL post_reset_idle cyc=%0d valid=%0b state=%0d exp valid=0 state=0", i, move_valid, fsm_state);
            end
        end
    endtask

    task automatic test_single_press();
        logic exp_v;
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            btn_tick  = (c == 0) ? 4'b0001 : 4'b0000;
            btn_level = (c >= 1 && c <= 3) ? 4'b0001 : 4'b0000;
            @(posedge clk);
            #1;
            exp_v = (c + 1 == 1);
            tests_run++;
            if (move_valid !== exp_v) begin
                tests_failed++;
                $display("FAIL single_valid cyc=%0d got=%0b exp=%0b", c + 1, move_valid, exp_v);
            end else if (exp_v) begin
                tests_run++;
                if (move_dir !== 2'd0 || move_rep !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL single_content dir=%0d rep=%0b exp dir=0 rep=0", move_dir, move_rep);
                end
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic exp_v;
        int   cyc;
        apply_reset();
        for (int c = 0; c <= 25; c++) begin
            btn_tick  = (c == 0) ? 4'b0100 : 4'b0000;
            btn_level = (c >= 1 && c <= 19) ? 4'b0100 : 4'b0000;
            @(posedge clk);
            #1;
            cyc   = c + 1;
            exp_v = (cyc == 1 || cyc == 9 || cyc == 13 || cyc == 17);
            tests_run++;
            if (move_valid !== exp_v) begin
                tests_failed++;
                $display("FAIL hold_valid cyc=%0d got=%0b exp=%0b", cyc, move_valid, exp_v);
            end else if (exp_v) begin
                tests_run++;
                if (move_dir !== 2'd2 || move_rep !== (cyc != 1)) begin
                    tests_failed++;
                    $display("FAIL hold_content cyc=%0d dir=%0d rep=%0b exp dir=2 rep=%0b", cyc, move_dir, move_rep, cyc != 1);
                end
            end
            if (cyc == 10) begin
                tests_run++;
                if (fsm_state !== 2'd2) begin tests_failed++; $display("FAIL hold_state_repeat got=%0d exp=2", fsm_state); end
            end
            if (cyc == 22) begin
                tests_run++;
                if (fsm_state !== 2'd0) begin tests_failed++; $display("FAIL hold_state_idle got=%0d exp=0", fsm_state); end
            end
        end
    endtask

    task automatic test_priority();
        logic       exp_v;
        logic [1:0] exp_d;
        logic       exp_r;
        int         cyc;
        apply_reset();
        for (int c = 0; c <= 20; c++) begin
            btn_tick  = (c == 0) ? 4'b1010 : (c == 5) ? 4'b1000 : 4'b0000;
            btn_level = {(c >= 6) ? 1'b1 : 1'b0, 1'b0, (c >= 1) ? 1'b1 : 1'b0, 1'b0};
            @(posedge clk);
            #1;
            cyc   = c + 1;
            exp_v = (cyc == 1 || cyc == 6 || cyc == 14 || cyc == 18);
            exp_d = (cyc == 1) ? 2'd1 : 2'd3;
            exp_r = (cyc == 14 || cyc == 18);
            tests_run++;
            if (move_valid !== exp_v) begin
                tests_failed++;
                $display("FAIL prio_valid cyc=%0d got=%0b exp=%0b", cyc, move_valid, exp_v);
            end else if (exp_v) begin
                tests_run++;
                if (move_dir !== exp_d || move_rep !== exp_r) begin
                    tests_failed++;
                    $display("FAIL prio_content cyc=%0d dir=%0d rep=%0b exp dir=%0d rep=%0b", cyc, move_dir, move_rep, exp_d, exp_r);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        move_ready = 1'b0;
        for (int c = 0; c <= 19; c++) begin
            btn_tick  = (c == 0) ? 4'b0100 : 4'b0000;
            btn_level = (c >= 1) ? 4'b0100 : 4'b0000;
            @(posedge clk);
            #1;
            tests_run++;
            if (move_valid !== 1'b1 || move_dir !== 2'd2 || move_rep !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stable cyc=%0d valid=%0b dir=%0d rep=%0b exp valid=1 dir=2 rep=0", c + 1, move_valid, move_dir, move_rep);
            end
        end
        tests_run++;
        if (drop_cnt !== 8'd3) begin tests_failed++; $display("FAIL bp_drop got=%0d exp=3", drop_cnt); end
        btn_level  = 4'd0;
        move_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (move_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_accept got=%0b exp=0", move_valid); end
        tests_run++;
        if (drop_cnt !== 8'd3) begin tests_failed++; $display("FAIL bp_drop_after got=%0d exp=3", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        int   cyc;
        apply_reset();
        for (int c = 0; c <= 5; c++) begin
            btn_tick  = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
            btn_level = 4'b0000;
            @(posedge clk);
            #1;
            cyc   = c + 1;
            exp_v = (cyc == 1 || cyc == 2);
            tests_run++;
            if (move_valid !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", cyc, move_valid, exp_v);
            end else if (exp_v) begin
                tests_run++;
                if (move_dir !== 2'(cyc - 1) || move_rep !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_content cyc=%0d dir=%0d rep=%0b exp dir=%0d rep=0", cyc, move_dir, move_rep, cyc - 1);
                end
            end
        end
    endtask

    task automatic test_grace_release();
        apply_reset();
        btn_tick  = 4'b1000;
        btn_level = 4'b0000;
        @(posedge clk);
        #1;
        btn_tick = 4'b0000;
        @(posedge clk);
        #1;
        tests_run++;
        if (fsm_state !== 2'd1) begin tests_failed++; $display("FAIL grace_hold got=%0d exp=1", fsm_state); end
        @(posedge clk);
        #1;
        tests_run++;
        if (fsm_state !== 2'd0) begin tests_failed++; $display("FAIL grace_release got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_saturation();
        apply_reset();
        move_ready = 1'b0;
        for (int c = 0; c <= 269; c++) begin
            btn_tick  = 4'b0001;
            btn_level = 4'b0001;
            @(posedge clk);
            #1;
            if (c == 254 || c == 255) begin
                tests_run++;
                if (drop_cnt !== 8'(c)) begin
                    tests_failed++;
                    $display("FAIL sat_edge cyc=%0d got=%0d exp=%0d", c + 1, drop_cnt, c);
                end
            end
        end
        tests_run++;
        if (drop_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_hold got=%0d exp=255", drop_cnt); end
        tests_run++;
        if (move_valid !== 1'b1 || move_dir !== 2'd0 || move_rep !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_pending valid=%0b dir=%0d rep=%0b exp valid=1 dir=0 rep=0", move_valid, move_dir, move_rep);
        end
        reset    = 1'b0;
        btn_tick = 4'b0000;
        @(posedge clk);
        #1;
        tests_run++;
        if (move_valid !== 1'b0) begin tests_failed++; $display("FAIL midrun_reset_valid got=%0b exp=0", move_valid); end
        tests_run++;
        if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL midrun_reset_drop got=%0d exp=0", drop_cnt); end
        reset = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        btn_level    = 4'd0;
        btn_tick     = 4'd0;
        move_ready   = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_priority();
        test_back_pressure();
        test_back_to_back();
        test_grace_release();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
